// File: rtl/avl_mem_arb.sv
// Two-master Avalon-MM arbiter (instruction fetch + data) onto one pipelined slave.
// Round-robin grant with lock-on-stall; an ID FIFO routes in-order read returns.
module avl_mem_arb #(
    parameter int OUTST_DEPTH = 4,
    parameter int ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] imem_address,
    input  logic              imem_read,
    output logic              imem_waitrequest,
    output logic              imem_readdatavalid,
    input  logic [ADDR_W-1:0] dmem_address,
    input  logic              dmem_read,
    input  logic              dmem_write,
    input  logic [31:0]       dmem_writedata,
    input  logic [3:0]        dmem_byteenable,
    output logic              dmem_waitrequest,
    output logic              dmem_readdatavalid,
    output logic [31:0]       rsp_readdata,
    output logic [1:0]        rsp_response,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_read,
    output logic              mem_write,
    output logic [31:0]       mem_writedata,
    output logic [3:0]        mem_byteenable,
    input  logic              mem_waitrequest,
    input  logic [31:0]       mem_readdata,
    input  logic              mem_readdatavalid,
    input  logic [1:0]        mem_response
);
    localparam int PTR_W = $clog2(OUTST_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {
        M_IMEM = 1'b0,
        M_DMEM = 1'b1
    } master_t;

    master_t                prio_q;
    master_t                lock_id_q;
    logic                   lock_q;
    logic [OUTST_DEPTH-1:0] id_fifo;
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [CNT_W-1:0]       count;

    logic fifo_full;
    logic fifo_empty;
    logic imem_ok;
    logic dmem_ok;
    logic gnt_imem;
    logic gnt_dmem;
    logic accept;
    logic push;
    logic pop;
    logic head;

    assign fifo_full  = (count == CNT_W'(OUTST_DEPTH));
    assign fifo_empty = (count == '0);

    // A full ID FIFO blocks reads only; a dmem read+write is treated as a read.
    assign imem_ok = imem_read & ~fifo_full;
    assign dmem_ok = dmem_read ? ~fifo_full : dmem_write;

    always_comb begin
        gnt_imem = 1'b0;
        gnt_dmem = 1'b0;
        if (!rst) begin
            if (lock_q) begin
                gnt_imem = (lock_id_q == M_IMEM) & imem_ok;
                gnt_dmem = (lock_id_q == M_DMEM) & dmem_ok;
            end else if (imem_ok && dmem_ok) begin
                gnt_imem = (prio_q == M_IMEM);
                gnt_dmem = (prio_q == M_DMEM);
            end else begin
                gnt_imem = imem_ok;
                gnt_dmem = dmem_ok;
            end
        end
    end

    assign mem_read       = gnt_imem | (gnt_dmem & dmem_read);
    assign mem_write      = gnt_dmem & dmem_write & ~dmem_read;
    assign mem_address    = gnt_dmem ? dmem_address : imem_address;
    assign mem_writedata  = dmem_writedata;
    assign mem_byteenable = gnt_dmem ? dmem_byteenable : 4'hF;

    assign imem_waitrequest = gnt_imem ? mem_waitrequest : 1'b1;
    assign dmem_waitrequest = gnt_dmem ? mem_waitrequest : 1'b1;

    assign accept = (gnt_imem | gnt_dmem) & ~mem_waitrequest;
    assign push   = accept & mem_read;
    // Returns arriving with no recorded ID (e.g. after reset) are dropped.
    assign pop    = mem_readdatavalid & ~fifo_empty & ~rst;
    assign head   = id_fifo[rd_ptr];

    assign imem_readdatavalid = pop & (head == 1'b0);
    assign dmem_readdatavalid = pop & (head == 1'b1);
    assign rsp_readdata       = mem_readdata;
    assign rsp_response       = mem_response;

    always_ff @(posedge clk) begin
        if (rst) begin
            prio_q    <= M_DMEM;
            lock_id_q <= M_IMEM;
            lock_q    <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
        end else begin
            if (accept) begin
                prio_q <= gnt_dmem ? M_IMEM : M_DMEM;
                lock_q <= 1'b0;
            end else if (gnt_imem || gnt_dmem) begin
                lock_q    <= 1'b1;
                lock_id_q <= gnt_dmem ? M_DMEM : M_IMEM;
            end
            if (push) begin
                id_fifo[wr_ptr] <= gnt_dmem;
                wr_ptr          <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_avl_mem_arb.sv
// Directed bench for avl_mem_arb: a queue-based reference model checked every cycle,
// plus literal expectations for the arbitration, stall, full-FIFO and reset scenarios.
module tb_avl_mem_arb;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_address;
    logic        imem_read;
    logic        imem_waitrequest;
    logic        imem_readdatavalid;
    logic [31:0] dmem_address;
    logic        dmem_read;
    logic        dmem_write;
    logic [31:0] dmem_writedata;
    logic [3:0]  dmem_byteenable;
    logic        dmem_waitrequest;
    logic        dmem_readdatavalid;
    logic [31:0] rsp_readdata;
    logic [1:0]  rsp_response;
    logic [31:0] mem_address;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_writedata;
    logic [3:0]  mem_byteenable;
    logic        mem_waitrequest;
    logic [31:0] mem_readdata;
    logic        mem_readdatavalid;
    logic [1:0]  mem_response;

    avl_mem_arb #(.OUTST_DEPTH(DEPTH), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .imem_address(imem_address), .imem_read(imem_read),
        .imem_waitrequest(imem_waitrequest), .imem_readdatavalid(imem_readdatavalid),
        .dmem_address(dmem_address), .dmem_read(dmem_read), .dmem_write(dmem_write),
        .dmem_writedata(dmem_writedata), .dmem_byteenable(dmem_byteenable),
        .dmem_waitrequest(dmem_waitrequest), .dmem_readdatavalid(dmem_readdatavalid),
        .rsp_readdata(rsp_readdata), .rsp_response(rsp_response),
        .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_byteenable(mem_byteenable),
        .mem_waitrequest(mem_waitrequest), .mem_readdata(mem_readdata),
        .mem_readdatavalid(mem_readdatavalid), .mem_response(mem_response)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errs    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: who may be granted, from the arbitration rules, and a queue of
    // master IDs for reads still owed a return.
    int m_prio = 1;      // master that wins a tie: 0 imem, 1 dmem
    bit m_lock = 1'b0;
    int m_lock_who = 0;
    int q[$];

    always @(negedge clk) begin
        bit full, i_ok, d_ok, exp_rd, exp_wr, exp_iw, exp_dw, exp_irdv, exp_drdv;
        int who;
        full   = (q.size() == DEPTH);
        i_ok   = imem_read && !full;
        d_ok   = dmem_read ? !full : dmem_write;
        who    = -1;
        if (rst) who = -1;
        else if (m_lock) who = (m_lock_who == 0) ? (i_ok ? 0 : -1) : (d_ok ? 1 : -1);
        else if (i_ok && d_ok) who = m_prio;
        else if (i_ok) who = 0;
        else if (d_ok) who = 1;

        exp_rd   = (who == 0) || (who == 1 && dmem_read);
        exp_wr   = (who == 1) && dmem_write && !dmem_read;
        exp_iw   = (who == 0) ? mem_waitrequest : 1'b1;
        exp_dw   = (who == 1) ? mem_waitrequest : 1'b1;
        exp_irdv = !rst && mem_readdatavalid && q.size() > 0 && q[0] == 0;
        exp_drdv = !rst && mem_readdatavalid && q.size() > 0 && q[0] == 1;

        check("mem_read", {31'b0, mem_read}, {31'b0, exp_rd});
        check("mem_write", {31'b0, mem_write}, {31'b0, exp_wr});
        check("imem_waitrequest", {31'b0, imem_waitrequest}, {31'b0, exp_iw});
        check("dmem_waitrequest", {31'b0, dmem_waitrequest}, {31'b0, exp_dw});
        check("imem_readdatavalid", {31'b0, imem_readdatavalid}, {31'b0, exp_irdv});
        check("dmem_readdatavalid", {31'b0, dmem_readdatavalid}, {31'b0, exp_drdv});
        check("rsp_readdata", rsp_readdata, mem_readdata);
        check("rsp_response", {30'b0, rsp_response}, {30'b0, mem_response});
        if (who >= 0) begin
            check("mem_address", mem_address, (who == 1) ? dmem_address : imem_address);
            check("mem_byteenable", {28'b0, mem_byteenable},
                  {28'b0, (who == 1) ? dmem_byteenable : 4'hF});
        end
        if (exp_wr) check("mem_writedata", mem_writedata, dmem_writedata);

        if (rst) begin
            q.delete();
            m_prio = 1;
            m_lock = 1'b0;
        end else begin
            if (exp_irdv || exp_drdv) void'(q.pop_front());
            if (who >= 0) begin
                if (!mem_waitrequest) begin
                    if (exp_rd) q.push_back(who);
                    m_prio = (who == 0) ? 1 : 0;
                    m_lock = 1'b0;
                end else begin
                    m_lock = 1'b1;
                    m_lock_who = who;
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic ret(input logic v, input logic [31:0] d);
        mem_readdatavalid = v;
        mem_readdata      = d;
        mem_response      = d[1:0];
    endtask

    int pulses;

    initial begin
        rst = 1'b1;
        imem_address = 32'h0; imem_read = 1'b0;
        dmem_address = 32'h0; dmem_read = 1'b0; dmem_write = 1'b0;
        dmem_writedata = 32'h0; dmem_byteenable = 4'h0;
        mem_waitrequest = 1'b0;
        ret(1'b0, 32'h0);

        // Reset: requests present but nothing issued
        imem_read = 1'b1; dmem_read = 1'b1;
        cyc(); cyc();
        sample();
        check("rst_mem_read", {31'b0, mem_read}, 32'd0);
        check("rst_imem_wait", {31'b0, imem_waitrequest}, 32'd1);
        check("rst_dmem_wait", {31'b0, dmem_waitrequest}, 32'd1);
        cyc();
        rst = 1'b0;

        // Both read every cycle: dmem, imem, dmem, imem, returns routed in order
        imem_address = 32'h1000; dmem_address = 32'h2000;
        sample(); check("rr0_addr", mem_address, 32'h2000);
        cyc(); ret(1'b1, 32'hA0A0_0001);
        sample(); check("rr1_addr", mem_address, 32'h1000);
        check("rr1_drdv", {31'b0, dmem_readdatavalid}, 32'd1);
        cyc(); ret(1'b1, 32'hA0A0_0002);
        sample(); check("rr2_addr", mem_address, 32'h2000);
        check("rr2_irdv", {31'b0, imem_readdatavalid}, 32'd1);
        cyc(); ret(1'b1, 32'hA0A0_0003);
        sample(); check("rr3_addr", mem_address, 32'h1000);
        check("rr3_drdv", {31'b0, dmem_readdatavalid}, 32'd1);
        cyc(); imem_read = 1'b0; dmem_read = 1'b0; ret(1'b1, 32'hA0A0_0004);
        sample(); check("rr4_irdv", {31'b0, imem_readdatavalid}, 32'd1);
        cyc(); ret(1'b1, 32'hA0A0_0005);
        sample(); check("drop_empty", {30'b0, imem_readdatavalid, dmem_readdatavalid}, 32'd0);
        cyc(); ret(1'b0, 32'h0);

        // Stall lock: imem at 0x100 held while dmem waits
        imem_read = 1'b1; imem_address = 32'h100; mem_waitrequest = 1'b1;
        dmem_address = 32'h200;
        for (int i = 0; i < 4; i++) begin
            if (i == 1) dmem_read = 1'b1;
            if (i == 3) mem_waitrequest = 1'b0;
            sample();
            check("lock_addr", mem_address, 32'h100);
            check("lock_dwait", {31'b0, dmem_waitrequest}, 32'd1);
            cyc();
        end
        imem_read = 1'b0;
        sample(); check("after_lock_addr", mem_address, 32'h200);
        cyc(); dmem_read = 1'b0;

        // Outstanding [i,d]: accept a dmem read while imem returns, count stays 2
        dmem_read = 1'b1; dmem_address = 32'h300; ret(1'b1, 32'hB0B0_0001);
        sample();
        check("same_irdv", {31'b0, imem_readdatavalid}, 32'd1);
        check("same_dwait", {31'b0, dmem_waitrequest}, 32'd0);
        cyc(); dmem_read = 1'b0; ret(1'b0, 32'h0);

        // Two more reads fill the FIFO to 4
        imem_read = 1'b1; imem_address = 32'h400;
        cyc(); cyc();
        sample();
        check("full_iwait", {31'b0, imem_waitrequest}, 32'd1);
        check("full_mem_read", {31'b0, mem_read}, 32'd0);
        dmem_write = 1'b1; dmem_writedata = 32'hDEADBEEF; dmem_byteenable = 4'b0011;
        dmem_address = 32'h500;
        sample();
        check("full_wr", {31'b0, mem_write}, 32'd1);
        check("full_wr_dwait", {31'b0, dmem_waitrequest}, 32'd0);
        check("full_wr_data", mem_writedata, 32'hDEADBEEF);
        check("full_wr_be", {28'b0, mem_byteenable}, 32'h3);
        check("full_wr_iwait", {31'b0, imem_waitrequest}, 32'd1);
        cyc(); dmem_write = 1'b0; ret(1'b1, 32'hB0B0_0002);
        sample();
        check("full_pop_iwait", {31'b0, imem_waitrequest}, 32'd1);
        check("full_pop_drdv", {31'b0, dmem_readdatavalid}, 32'd1);
        cyc(); ret(1'b0, 32'h0);
        sample(); check("after_pop_iwait", {31'b0, imem_waitrequest}, 32'd0);
        cyc(); imem_read = 1'b0;

        // One return leaves 3 outstanding; reset must discard them
        ret(1'b1, 32'hB0B0_0003);
        cyc(); ret(1'b0, 32'h0);
        rst = 1'b1;
        cyc(); cyc();
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            ret(1'b1, 32'hC0C0_0000 + i);
            sample();
            if (imem_readdatavalid || dmem_readdatavalid) pulses++;
            cyc();
        end
        ret(1'b0, 32'h0);
        check("post_rst_pulses", pulses, 32'd0);

        // Read+write together issues a read only
        dmem_read = 1'b1; dmem_write = 1'b1; dmem_address = 32'h600;
        sample();
        check("rw_read", {31'b0, mem_read}, 32'd1);
        check("rw_write", {31'b0, mem_write}, 32'd0);
        cyc(); dmem_read = 1'b0; dmem_write = 1'b0; ret(1'b1, 32'hD0D0_0001);
        sample(); check("rw_drdv", {31'b0, dmem_readdatavalid}, 32'd1);
        cyc(); ret(1'b0, 32'h0);
        cyc(); cyc();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule

// File: doc/avl_mem_arb.md
AVL_MEM_ARB -- requirements
Module: avl_mem_arb

Interface
REQ-001 Parameters SHALL be:
- OUTST_DEPTH, default 4: max outstanding reads; power of 2, 2..16.
- ADDR_W, default 32: address width.
REQ-002 Ports SHALL be exactly:
- clk  in  1  single clock; all state on rising edge
- rst  in  1  synchronous active-high reset
- imem_address  in  ADDR_W  instruction fetch address
- imem_read  in  1  fetch request
- imem_waitrequest  out  1  fetch command not accepted
- imem_readdatavalid  out  1  rsp_readdata belongs to imem
- dmem_address  in  ADDR_W  data address
- dmem_read  in  1  data read request
- dmem_write  in  1  data write request
- dmem_writedata  in  32  write data
- dmem_byteenable  in  4  byte lanes
- dmem_waitrequest  out  1  data command not accepted
- dmem_readdatavalid  out  1  rsp_readdata belongs to dmem
- rsp_readdata  out  32  read data, shared by both masters
- rsp_response  out  2  read response, shared by both masters
- mem_address  out  ADDR_W  to shared slave
- mem_read  out  1  to shared slave
- mem_write  out  1  to shared slave
- mem_writedata  out  32  to shared slave
- mem_byteenable  out  4  to shared slave; 4'hF for imem
- mem_waitrequest  in  1  slave stall
- mem_readdata  in  32  slave read data
- mem_readdatavalid  in  1  slave read data valid, in command order
- mem_response  in  2  slave response

Function
REQ-003 Requesting masters: imem when imem_read=1; dmem when dmem_read|dmem_write.
REQ-004 dmem_read and dmem_write both 1 SHALL issue a read; the write is ignored.
REQ-005 Grant SHALL be combinational each cycle, round-robin on a 1-bit priority pointer: sole requester wins; if both request, the pointer's master wins.
REQ-006 Command accepted = granted command presented with mem_waitrequest=0; on acceptance the pointer SHALL move to the non-granted master.
REQ-007 Lock: command presented with mem_waitrequest=1 SHALL set lock_q, freezing the grant until acceptance; lock_q clears the cycle after acceptance.
REQ-008 Granted master's waitrequest SHALL equal mem_waitrequest; non-granted or idle master's waitrequest SHALL be 1.
REQ-009 mem_* command outputs SHALL mirror the granted master; with no grant, mem_read=mem_write=0 and other outputs are don't-care.
REQ-010 ID FIFO (OUTST_DEPTH x 1 bit, 0=imem, 1=dmem) SHALL push on each accepted read and pop on mem_readdatavalid.
REQ-011 Push and pop in the same cycle SHALL leave the count unchanged.
REQ-012 FIFO full: read requests SHALL NOT be granted (waitrequest=1); dmem writes remain grantable; full with pop same cycle still blocks (no bypass).
REQ-013 Read return: imem_readdatavalid = mem_readdatavalid & head==0; dmem_readdatavalid = mem_readdatavalid & head==1; zero-cycle latency.
REQ-014 rsp_readdata/rsp_response SHALL pass mem_readdata/mem_response through combinationally.
REQ-015 mem_readdatavalid with FIFO empty SHALL be dropped: no master readdatavalid, no pop.
REQ-016 Writes SHALL NOT enter the FIFO and produce no return.

Reset
REQ-017 While rst=1: pointer=dmem, lock_q=0, FIFO empty. Outputs: mem_read=mem_write=0, both waitrequests=1, both readdatavalids=0.
REQ-018 Reset mid-operation SHALL discard outstanding IDs; subsequent returns fall under REQ-015.

Verification
REQ-019 Both masters read every cycle, mem_waitrequest=0 -> accepts alternate dmem, imem, dmem, imem; returns route to matching readdatavalid.
REQ-020 imem read at 0x100 with mem_waitrequest=1 for 3 cycles while dmem requests -> mem_address stays 0x100 for 4 cycles; dmem_waitrequest=1 throughout.
REQ-021 OUTST_DEPTH=4, 4 accepted reads, no returns -> 5th read waitrequest=1; dmem write 0xDEADBEEF, byteenable 4'b0011 still accepted; read accepted the cycle after 1st return.
REQ-022 Same-cycle read accept and return at count 2 -> count stays 2; IDs returned in issue order.
REQ-023 rst asserted with 3 reads outstanding, then 3 mem_readdatavalid pulses -> zero master readdatavalid pulses.
